fetch_stage: RTL

- Instruction fetch front end that sits between the instruction ROM (`rom`) and the CPU decode stage inside `sopc`.
- Holds the PC and issues sequential reads to the 1-cycle-latency synchronous ROM.
- Buffers returned words in a small prefetch FIFO and hands {pc, instruction} to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of buffered and in-flight fetches.

---
 rtl/cpu_defines.sv | 17 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_defines.sv
// rtl/cpu_defines.sv - shared CPU widths, constants and fetch entry type
package cpu_defines;

    localparam int WORD_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] INSTRUCTION_NOP  = 32'h0000_0000;
    localparam logic [ADDR_WIDTH-1:0] PC_INCREMENT     = 32'd4;

    // One prefetched instruction tagged with the address it was read from.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instruction} entries
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-low reset
//   push, push_entry   write one entry at the edge
//   pop                retire the head entry at the edge
//   flush              empty the FIFO; wins over push
//   count              number of stored entries (0..DEPTH)
//   head               oldest entry, meaningful only when count != 0
module fetch_fifo
    import cpu_defines::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t          mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop together leave count unchanged, even when full.
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !flush && push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end between ROM and decode
//
// Ports:
//   clock, reset                        rising-edge clock, synchronous active-low reset
//   rom_enable, rom_address, rom_data   1-cycle-latency synchronous ROM read port
//   out_valid, out_ready                handshake towards decode
//   out_pc, out_instruction             presented {pc, instruction}
//   redirect_valid, redirect_target     one-cycle branch/jump strobe from execute
module fetch_stage
    import cpu_defines::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                    DEPTH    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  rom_enable,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [WORD_WIDTH-1:0] out_instruction,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic                  pop;
    logic                  issue;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    fetch_entry_t          head;
    fetch_entry_t          last_entry;
    fetch_entry_t          push_entry;
    logic                  unused_target_bits;

    assign unused_target_bits = ^redirect_target[1:0];

    // Slots that will be taken after this edge if nothing new is issued.
    // pop implies count >= 1, so this cannot underflow.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

    assign out_valid = reset & (count != '0) & !redirect_valid;
    assign pop       = out_valid & out_ready;
    assign issue     = reset & !redirect_valid & (occupancy < DEPTH_LIMIT);

    assign rom_enable  = issue;
    assign rom_address = pc;

    // The word returned this cycle belongs to the address issued last cycle.
    // A redirect in this cycle flushes the FIFO, which also drops this word.
    assign push_entry = '{pc: inflight_pc, instruction: rom_data};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head       (head)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc          <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
            inflight    <= 1'b0;
            inflight_pc <= '0;
            last_entry  <= '{pc: '0, instruction: INSTRUCTION_NOP};
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (redirect_valid) begin
                pc <= {redirect_target[ADDR_WIDTH-1:2], 2'b00};
            end else if (issue) begin
                pc <= pc + PC_INCREMENT;
            end
            // Remember what decode last saw so an empty FIFO keeps it steady.
            if (count != '0) begin
                last_entry <= head;
            end
        end
    end

    always_comb begin
        out_pc          = '0;
        out_instruction = '0;
        if (reset) begin
            if (count != '0) begin
                out_pc          = head.pc;
                out_instruction = head.instruction;
            end else begin
                out_pc          = last_entry.pc;
                out_instruction = last_entry.instruction;
            end
        end
    end

endmodule
